// File: rtl/wall_map_arbiter.sv
// wall_map_arbiter: owns the single-port wall map (GRID_H rows x GRID_W bits,
// one bit per grid cell). The VGA reader has absolute priority; in free cycles
// the game collision query and the game wall write are round-robin arbitrated.
// The map is cleared one row per cycle after reset and on a new-game pulse.
// Optional feature macro: WALL_BORDER_EN -- the clear sequence draws a solid
// border around the arena instead of writing all zeros.
module wall_map_arbiter #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 44,
  parameter int XW     = 6,
  parameter int YW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  output logic          o_ready,
  input  logic          i_vga_buzy,
  input  logic [XW-1:0] i_vga_x,
  input  logic [YW-1:0] i_vga_y,
  output logic          o_vga_wall,
  input  logic          i_q_req,
  input  logic [XW-1:0] i_q_x,
  input  logic [YW-1:0] i_q_y,
  output logic          o_q_gnt,
  output logic          o_q_valid,
  output logic          o_q_wall,
  input  logic          i_w_req,
  input  logic [XW-1:0] i_w_x,
  input  logic [YW-1:0] i_w_y,
  input  logic          i_w_data,
  output logic          o_w_gnt
);

  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

`ifdef WALL_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state, state_next;
  logic [RW-1:0]       row;
  logic                rr_w;          // 1 = write wins the next tie
  logic                vga_prev_buzy;
  logic [XW-1:0]       vga_last_x;
  logic [YW-1:0]       vga_last_y;
  logic [GRID_W-1:0]   mem [GRID_H];

  logic                run_ok;
  logic                vga_slot;
  logic                q_gnt;
  logic                w_gnt;
  logic [XW-1:0]       rd_x;
  logic [YW-1:0]       rd_y;
  logic                rd_bit;

  // Row contents written by the clear sequence.
  function automatic logic [GRID_W-1:0] clear_pattern(input logic [RW-1:0] r);
    logic [GRID_W-1:0] p;
    p = '0;
    if (BORDER_EN) begin
      if (r == '0 || r == RW'(GRID_H - 1)) begin
        p = '1;
      end else begin
        p[0]        = 1'b1;
        p[GRID_W-1] = 1'b1;
      end
    end
    return p;
  endfunction

  // Cells outside the arena behave as solid wall and cannot be written.
  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking assignments only.
    if (rst) state <= S_CLEAR;
    else     state <= state_next;
  end

  // Next state: clear runs to the last row; a new-game pulse restarts it.
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (!i_clear && row == RW'(GRID_H - 1)) state_next = S_RUN;
      S_RUN:   if (i_clear) state_next = S_CLEAR;
      default: state_next = S_CLEAR;
    endcase
  end

  // Port slot selection: VGA on a new address, otherwise one game grant.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    vga_slot = 1'b0;
    q_gnt    = 1'b0;
    w_gnt    = 1'b0;
    rd_x     = i_q_x;
    rd_y     = i_q_y;
    run_ok   = (state == S_RUN) && !rst;
    if (run_ok && i_vga_buzy &&
        (!vga_prev_buzy || i_vga_x != vga_last_x || i_vga_y != vga_last_y)) begin
      vga_slot = 1'b1;
      rd_x     = i_vga_x;
      rd_y     = i_vga_y;
    end else if (run_ok && o_ready && !i_clear) begin
      if (i_q_req && (!i_w_req || !rr_w)) q_gnt = 1'b1;
      else if (i_w_req)                   w_gnt = 1'b1;
    end
  end

  assign rd_bit  = in_range(rd_x, rd_y) ? mem[rd_y][rd_x] : 1'b1;
  assign o_q_gnt = q_gnt;
  assign o_w_gnt = w_gnt;

  // Map store: clear rows during S_CLEAR, game writes while running.
  always_ff @(posedge clk) begin
    // NOTE: the store has no reset; the clear sequence defines its contents.
    if (!rst) begin
      if (state == S_CLEAR)
        mem[row] <= clear_pattern(row);
      else if (w_gnt && in_range(i_w_x, i_w_y))
        mem[i_w_y][i_w_x] <= i_w_data;
    end
  end

  // Control registers: row counter, ready, round-robin pointer, read results.
  always_ff @(posedge clk) begin
    if (rst) begin
      row           <= '0;
      o_ready       <= 1'b0;
      rr_w          <= 1'b0;
      vga_prev_buzy <= 1'b0;
      vga_last_x    <= '0;
      vga_last_y    <= '0;
      o_vga_wall    <= 1'b0;
      o_q_valid     <= 1'b0;
      o_q_wall      <= 1'b0;
    end else begin
      o_ready <= (state_next == S_RUN);
      if (state == S_CLEAR && !i_clear && row != RW'(GRID_H - 1))
        row <= row + RW'(1);
      else
        row <= '0;
      if (q_gnt || w_gnt) rr_w <= ~rr_w;
      o_q_valid <= q_gnt;
      if (q_gnt) o_q_wall <= rd_bit;
      if (state == S_RUN) begin
        vga_prev_buzy <= i_vga_buzy;
        if (vga_slot) begin
          vga_last_x <= i_vga_x;
          vga_last_y <= i_vga_y;
          o_vga_wall <= rd_bit;
        end
      end else begin
        vga_prev_buzy <= 1'b0;
        o_vga_wall    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wall_map_arbiter.sv
// Self-checking bench for wall_map_arbiter: directed steps plus randomized
// queries/writes against a cell-array reference model of the wall map.
module tb_wall_map_arbiter;

  localparam int GRID_W = 64;
  localparam int GRID_H = 44;
  localparam int XW     = 6;
  localparam int YW     = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_clear;
  logic          o_ready;
  logic          i_vga_buzy;
  logic [XW-1:0] i_vga_x;
  logic [YW-1:0] i_vga_y;
  logic          o_vga_wall;
  logic          i_q_req;
  logic [XW-1:0] i_q_x;
  logic [YW-1:0] i_q_y;
  logic          o_q_gnt;
  logic          o_q_valid;
  logic          o_q_wall;
  logic          i_w_req;
  logic [XW-1:0] i_w_x;
  logic [YW-1:0] i_w_y;
  logic          i_w_data;
  logic          o_w_gnt;

  int tests = 0;
  int fails = 0;

  bit model_map [GRID_H][GRID_W];
  bit rr_model;   // 1 = write should win the next tie

  wall_map_arbiter #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (i_clear),
    .o_ready    (o_ready),
    .i_vga_buzy (i_vga_buzy),
    .i_vga_x    (i_vga_x),
    .i_vga_y    (i_vga_y),
    .o_vga_wall (o_vga_wall),
    .i_q_req    (i_q_req),
    .i_q_x      (i_q_x),
    .i_q_y      (i_q_y),
    .o_q_gnt    (o_q_gnt),
    .o_q_valid  (o_q_valid),
    .o_q_wall   (o_q_wall),
    .i_w_req    (i_w_req),
    .i_w_x      (i_w_x),
    .i_w_y      (i_w_y),
    .i_w_data   (i_w_data),
    .o_w_gnt    (o_w_gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_n(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Map after a clear, derived from the arena description.
  function automatic void model_init();
    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++) begin
`ifdef WALL_BORDER_EN
        model_map[y][x] = (y == 0 || y == GRID_H - 1 || x == 0 || x == GRID_W - 1);
`else
        model_map[y][x] = 1'b0;
`endif
      end
  endfunction

  function automatic bit model_rd(input int x, input int y);
    if (x < 0 || x >= GRID_W || y < 0 || y >= GRID_H) return 1'b1;
    return model_map[y][x];
  endfunction

  // Counts cycles with o_ready low, starting just after the causing edge.
  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_query(input int x, input int y, input string tag);
    int n;
    bit got;
    bit exp_wall;
    @(posedge clk); #1;
    i_q_req = 1'b1;
    i_q_x   = x[XW-1:0];
    i_q_y   = y[YW-1:0];
    n = 0; got = 1'b0; exp_wall = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (o_q_gnt === 1'b1) begin
        got      = 1'b1;
        exp_wall = model_rd(x, y);
        rr_model = !rr_model;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_gnt"}, got, 1'b1);
    @(posedge clk); #1;
    i_q_req = 1'b0;
    if (got) begin
      @(negedge clk);
      check({tag, "_valid"}, o_q_valid, 1'b1);
      check({tag, "_wall"}, o_q_wall, exp_wall);
    end
  endtask

  task automatic do_write(input int x, input int y, input bit d, input string tag);
    int n;
    bit got;
    @(posedge clk); #1;
    i_w_req  = 1'b1;
    i_w_x    = x[XW-1:0];
    i_w_y    = y[YW-1:0];
    i_w_data = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (o_w_gnt === 1'b1) begin
        got = 1'b1;
        rr_model = !rr_model;
        if (x < GRID_W && y < GRID_H) model_map[y][x] = d;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_gnt"}, got, 1'b1);
    @(posedge clk); #1;
    i_w_req = 1'b0;
  endtask

  initial begin
    int  n;
    bit  saw_gnt;
    int  vx, vy, nx, ny, qx, qy;
    bit  slot, exp_q, prev_slot, prev_q, prev_q_exp, vga_hold_exp, new_data;

    rst = 1'b1; i_clear = 1'b0; i_vga_buzy = 1'b0; i_vga_x = '0; i_vga_y = '0;
    i_q_req = 1'b0; i_q_x = '0; i_q_y = '0;
    i_w_req = 1'b0; i_w_x = '0; i_w_y = '0; i_w_data = 1'b0;
    rr_model = 1'b0;
    model_init();

    // 1: reset state, clear latency, first queries.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b0);
    check("rst_q_gnt", o_q_gnt, 1'b0);
    check("rst_w_gnt", o_w_gnt, 1'b0);
    check("rst_q_valid", o_q_valid, 1'b0);
    check("rst_vga_wall", o_vga_wall, 1'b0);
    check("rst_q_wall", o_q_wall, 1'b0);
    wait_ready(n);
    check_n("rst_to_ready_cycles", n, 44);
    do_query(5, 5, "q_5_5");
    do_query(0, 7, "q_0_7");

    // 2: write then read back, both values.
    do_write(10, 20, 1'b1, "w_10_20_set");
    do_query(10, 20, "q_10_20_set");
    do_write(10, 20, 1'b0, "w_10_20_clr");
    do_query(10, 20, "q_10_20_clr");

    // 4: boundaries and out-of-range accesses.
    do_query(63, 43, "q_63_43");
    do_query(0, 44, "q_0_44");
    do_query(0, 63, "q_0_63");
    do_write(0, 50, 1'b1, "w_0_50");
    do_query(0, 6, "q_0_6_after_oor_w");
    do_query(0, 18, "q_0_18_after_oor_w");

    // Randomized queries and writes, including out-of-range rows.
    for (int i = 0; i < 40; i++) begin
      nx = $urandom_range(0, GRID_W - 1);
      ny = $urandom_range(0, 50);
      if ($urandom_range(0, 1) == 1) do_write(nx, ny, 1'($urandom_range(0, 1)), "rand_w");
      else                           do_query(nx, ny, "rand_q");
    end

    // 3: VGA stepping every 10 cycles with both game requests held on one cell.
    qx = $urandom_range(1, GRID_W - 2);
    qy = $urandom_range(1, GRID_H - 2);
    @(posedge clk); #1;
    i_q_x = qx[XW-1:0]; i_q_y = qy[YW-1:0];
    i_w_x = qx[XW-1:0]; i_w_y = qy[YW-1:0];
    i_w_data = 1'($urandom_range(0, 1));
    vx = -1; vy = -1;
    prev_slot = 1'b0; prev_q = 1'b0; prev_q_exp = 1'b0;
    vga_hold_exp = 1'b0; new_data = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) begin
        do begin
          nx = $urandom_range(0, GRID_W - 1);
          ny = $urandom_range(0, 50);
        end while (nx == vx && ny == vy);
        vx = nx; vy = ny;
        i_vga_x = vx[XW-1:0];
        i_vga_y = vy[YW-1:0];
      end
      if (new_data) i_w_data = 1'($urandom_range(0, 1));
      new_data = 1'b0;
      i_vga_buzy = 1'b1; i_q_req = 1'b1; i_w_req = 1'b1;
      @(negedge clk);
      check("t3_vga_wall", o_vga_wall, vga_hold_exp);
      check("t3_q_valid", o_q_valid, prev_q);
      if (prev_q) check("t3_q_wall", o_q_wall, prev_q_exp);
      slot = (c % 10 == 0);
      exp_q = 1'b0;
      if (slot) begin
        check("t3_slot_q_gnt", o_q_gnt, 1'b0);
        check("t3_slot_w_gnt", o_w_gnt, 1'b0);
        vga_hold_exp = model_rd(vx, vy);
      end else begin
        exp_q = !rr_model;
        check("t3_rr_q_gnt", o_q_gnt, exp_q);
        check("t3_rr_w_gnt", o_w_gnt, !exp_q);
        rr_model = !rr_model;
        if (exp_q) prev_q_exp = model_rd(qx, qy);
        else begin
          model_map[qy][qx] = i_w_data;
          new_data = 1'b1;
        end
      end
      prev_slot = slot;
      prev_q = !slot && exp_q;
    end
    @(posedge clk); #1;
    i_vga_buzy = 1'b0; i_q_req = 1'b0; i_w_req = 1'b0;
    @(negedge clk);
    check("t3_vga_wall_end", o_vga_wall, vga_hold_exp);
    check("t3_q_valid_end", o_q_valid, prev_q);
    if (prev_q) check("t3_q_wall_end", o_q_wall, prev_q_exp);

    // 5: new game with a walled cell and a pending query.
    do_write(5, 5, 1'b1, "t5_w_5_5");
    do_query(5, 5, "t5_q_5_5_before");
    @(posedge clk); #1;
    i_clear = 1'b1; i_q_req = 1'b1; i_q_x = 6'd5; i_q_y = 6'd5;
    @(negedge clk);
    check("t5_clear_cycle_q_gnt", o_q_gnt, 1'b0);
    @(posedge clk); #1;
    i_clear = 1'b0;
    model_init();
    n = 0; saw_gnt = 1'b0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      if (o_q_gnt || o_w_gnt) saw_gnt = 1'b1;
      n++;
      @(negedge clk);
    end
    check_n("t5_clear_cycles", n, 44);
    check("t5_no_gnt_in_clear", saw_gnt, 1'b0);
    check("t5_gnt_after_ready", o_q_gnt, 1'b1);
    rr_model = !rr_model;
    @(posedge clk); #1;
    i_q_req = 1'b0;
    @(negedge clk);
    check("t5_q_valid", o_q_valid, 1'b1);
    check("t5_q_wall", o_q_wall, model_rd(5, 5));

    // 6: reset in the middle of a clear, then round-robin pointer back at query.
    do_query(0, 44, "t6_q_oor");
    @(posedge clk); #1;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_rst_q_wall", o_q_wall, 1'b0);
    check("t6_rst_ready", o_ready, 1'b0);
    wait_ready(n);
    check_n("t6_rst_to_ready_cycles", n, 44);
    model_init();
    rr_model = 1'b0;
    @(posedge clk); #1;
    i_q_req = 1'b1; i_q_x = 6'd3; i_q_y = 6'd3;
    i_w_req = 1'b1; i_w_x = 6'd4; i_w_y = 6'd4; i_w_data = 1'b1;
    @(negedge clk);
    check("t6_tie_q_first", o_q_gnt, 1'b1);
    check("t6_tie_w_wait", o_w_gnt, 1'b0);
    @(posedge clk); #1;
    i_q_req = 1'b0;
    @(negedge clk);
    check("t6_w_second", o_w_gnt, 1'b1);
    check("t6_q_valid", o_q_valid, 1'b1);
    check("t6_q_wall", o_q_wall, model_rd(3, 3));
    model_map[4][4] = 1'b1;
    rr_model = 1'b0;
    @(posedge clk); #1;
    i_w_req = 1'b0;
    do_query(4, 4, "t6_q_4_4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
